cache_axi_arbiter: RTL and testbench

Shares one AXI-bridge cache-side port (read request/return, line write) between the instruction cache and the data cache.
- Reads: arbitrated, one outstanding burst at a time.
- Writes: data cache only, through a one-line write buffer.
- Reads to a line still held in the write buffer are blocked, so a read never overtakes a dirty-line writeback.

---
 rtl/cache_axi_arbiter_pkg.sv | 48 ++++
 rtl/cache_axi_arbiter_rd_arb2.sv | 28 ++
 rtl/cache_axi_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the cache-side AXI bridge arbiter.
// Holds the FSM state encodings, the request type codes, the requester IDs and
// the packed command payloads that the read and write paths latch.
package cache_axi_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned STRB_W = 4;

    // Address bits that identify a 16-byte cache line.
    localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFF0;

    localparam logic [TYPE_W-1:0] RT_LINE = 3'b100;
    localparam logic [TYPE_W-1:0] RT_WORD = 3'b010;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_RESP = 3'b100
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_REQ  = 3'b010,
        W_WAIT = 3'b100
    } wr_state_t;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [ADDR_W-1:0] addr;
    } rd_cmd_t;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
    } wr_cmd_t;

    // True when both addresses fall in the same cache line.
    function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return ((a ^ b) & LINE_MASK) == '0;
    endfunction

endpackage

// File: rtl/cache_axi_arbiter_rd_arb2.sv
// Two-way read arbiter: fixed dcache priority or round-robin.
// Ports:
//   i_req[1:0] : eligible requesters (bit 0 icache, bit 1 dcache)
//   i_last     : requester granted most recently (GNT_IC / GNT_DC)
//   i_prio     : 1 = dcache always wins a conflict, 0 = round-robin
//   o_gnt_c    : one-hot combinational grant, zero when nobody is eligible
module rd_arb2
    import cache_axi_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_prio,
    output logic [1:0] o_gnt_c
);

    // On a conflict the dcache wins under priority mode or when icache went last.
    always_comb begin
        o_gnt_c = i_req;
        if (i_req == 2'b11) begin
            if (i_prio || (i_last == GNT_IC)) begin
                o_gnt_c = 2'b10;
            end else begin
                o_gnt_c = 2'b01;
            end
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one cache-side AXI bridge port between the icache and the dcache.
// Reads are arbitrated with one burst outstanding; dcache writes go through a
// one-line write buffer; a read to a line held in that buffer is held back so
// it can never overtake the writeback.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   ic_rd_* / dc_rd_*             : cache read requests; *_rd_rdy grant pulse
//   ic_ret_valid / dc_ret_valid   : return-beat valid steered to the granted cache
//   dc_wr_*                       : dcache write pulse; dc_wr_rdy = buffer empty
//   rd_req/rd_type/rd_addr/rd_rdy : bridge read request channel
//   ret_valid/ret_last            : bridge return beats
//   wr_*                          : bridge write request channel, wr_done = B response
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int unsigned DC_PRIO = 1,
    parameter int unsigned LINE_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_rd_req,
    input  logic [2:0]        ic_rd_type,
    input  logic [31:0]       ic_rd_addr,
    output logic              ic_rd_rdy,
    output logic              ic_ret_valid,
    input  logic              dc_rd_req,
    input  logic [2:0]        dc_rd_type,
    input  logic [31:0]       dc_rd_addr,
    output logic              dc_rd_rdy,
    output logic              dc_ret_valid,
    input  logic              dc_wr_req,
    input  logic [2:0]        dc_wr_type,
    input  logic [31:0]       dc_wr_addr,
    input  logic [3:0]        dc_wr_wstrb,
    input  logic [LINE_W-1:0] dc_wr_data,
    output logic              dc_wr_rdy,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [31:0]       rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [31:0]       wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [LINE_W-1:0] wr_data,
    input  logic              wr_rdy,
    input  logic              wr_done
);

    rd_state_t         r_rd_state;
    rd_state_t         w_rd_next;
    wr_state_t         r_wr_state;
    wr_state_t         w_wr_next;
    logic              r_last_gnt;
    rd_cmd_t           r_rd_cmd;
    wr_cmd_t           r_wr_cmd;
    logic [LINE_W-1:0] r_wr_data;

    logic              w_wr_busy;
    logic              w_ic_blk;
    logic              w_dc_blk;
    logic [1:0]        w_elig;
    logic [1:0]        w_arb_gnt;
    logic              w_rd_start;
    logic              w_wr_start;

    // Line hazard: the buffered line while a write is in flight, otherwise the
    // line being written in this very cycle.
    assign w_wr_busy = (r_wr_state != W_IDLE);
    assign w_ic_blk  = w_wr_busy ? same_line(ic_rd_addr, r_wr_cmd.addr)
                                 : (dc_wr_req && same_line(ic_rd_addr, dc_wr_addr));
    assign w_dc_blk  = w_wr_busy ? same_line(dc_rd_addr, r_wr_cmd.addr)
                                 : (dc_wr_req && same_line(dc_rd_addr, dc_wr_addr));
    assign w_elig    = {dc_rd_req && !w_dc_blk, ic_rd_req && !w_ic_blk};

    rd_arb2 u_rd_arb2 (
        .i_req   (w_elig),
        .i_last  (r_last_gnt),
        .i_prio  (DC_PRIO != 0),
        .o_gnt_c (w_arb_gnt)
    );

    assign w_rd_start = (r_rd_state == R_IDLE) && (w_arb_gnt != 2'b00);
    assign w_wr_start = (r_wr_state == W_IDLE) && dc_wr_req;

    // Read FSM state register plus latched grant and command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_last_gnt <= GNT_IC;
            r_rd_cmd   <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_rd_start) begin
                if (w_arb_gnt[1]) begin
                    r_last_gnt <= GNT_DC;
                    r_rd_cmd   <= '{typ: dc_rd_type, addr: dc_rd_addr};
                end else begin
                    r_last_gnt <= GNT_IC;
                    r_rd_cmd   <= '{typ: ic_rd_type, addr: ic_rd_addr};
                end
            end
        end
    end

    // Read FSM next state and steering of grant pulses and return beats.
    always_comb begin
        w_rd_next    = r_rd_state;
        rd_req       = 1'b0;
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        ic_ret_valid = 1'b0;
        dc_ret_valid = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_rd_start) begin
                    w_rd_next = R_REQ;
                end
            end
            R_REQ: begin
                rd_req = 1'b1;
                if (rd_rdy) begin
                    ic_rd_rdy = (r_last_gnt == GNT_IC);
                    dc_rd_rdy = (r_last_gnt == GNT_DC);
                    w_rd_next = R_RESP;
                end
            end
            R_RESP: begin
                ic_ret_valid = ret_valid && (r_last_gnt == GNT_IC);
                dc_ret_valid = ret_valid && (r_last_gnt == GNT_DC);
                if (ret_valid && ret_last) begin
                    w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    assign rd_type = r_rd_cmd.typ;
    assign rd_addr = r_rd_cmd.addr;

    // Write FSM state register and one-line write buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cmd   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_wr_start) begin
                r_wr_cmd  <= '{typ: dc_wr_type, addr: dc_wr_addr, wstrb: dc_wr_wstrb};
                r_wr_data <= dc_wr_data;
            end
        end
    end

    // Write FSM next state; dc_wr_req outside W_IDLE and stray wr_done are dropped.
    always_comb begin
        w_wr_next = r_wr_state;
        wr_req    = 1'b0;
        dc_wr_rdy = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                dc_wr_rdy = !rst;
                if (dc_wr_req) begin
                    w_wr_next = W_REQ;
                end
            end
            W_REQ: begin
                wr_req = 1'b1;
                if (wr_rdy) begin
                    w_wr_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_done) begin
                    w_wr_next = W_IDLE;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    assign wr_type  = r_wr_cmd.typ;
    assign wr_addr  = r_wr_cmd.addr;
    assign wr_wstrb = r_wr_cmd.wstrb;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter. u_rr runs round-robin (DC_PRIO=0) and
// u_fp runs dcache priority (DC_PRIO=1); both see the same stimulus.
module tb_cache_axi_arbiter;

    logic         clk;
    logic         rst;
    logic         ic_rd_req;
    logic [2:0]   ic_rd_type;
    logic [31:0]  ic_rd_addr;
    logic         dc_rd_req;
    logic [2:0]   dc_rd_type;
    logic [31:0]  dc_rd_addr;
    logic         dc_wr_req;
    logic [2:0]   dc_wr_type;
    logic [31:0]  dc_wr_addr;
    logic [3:0]   dc_wr_wstrb;
    logic [127:0] dc_wr_data;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic         wr_rdy;
    logic         wr_done;

    logic         ic_rd_rdy, ic_ret_valid, dc_rd_rdy, dc_ret_valid, dc_wr_rdy;
    logic         rd_req, wr_req;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;

    logic         fp_ic_rd_rdy, fp_ic_ret_valid, fp_dc_rd_rdy, fp_dc_ret_valid, fp_dc_wr_rdy;
    logic         fp_rd_req, fp_wr_req;
    logic [2:0]   fp_rd_type, fp_wr_type;
    logic [31:0]  fp_rd_addr, fp_wr_addr;
    logic [3:0]   fp_wr_wstrb;
    logic [127:0] fp_wr_data;

    int checks = 0;
    int errors = 0;

    cache_axi_arbiter #(.DC_PRIO(0), .LINE_W(128)) u_rr (
        .clk(clk), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    cache_axi_arbiter #(.DC_PRIO(1), .LINE_W(128)) u_fp (
        .clk(clk), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(fp_ic_rd_rdy), .ic_ret_valid(fp_ic_ret_valid),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(fp_dc_rd_rdy), .dc_ret_valid(fp_dc_ret_valid),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(fp_dc_wr_rdy),
        .rd_req(fp_rd_req), .rd_type(fp_rd_type), .rd_addr(fp_rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last),
        .wr_req(fp_wr_req), .wr_type(fp_wr_type), .wr_addr(fp_wr_addr), .wr_wstrb(fp_wr_wstrb),
        .wr_data(fp_wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive point: just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for rd_req, accepts it with a one-cycle rd_rdy and records
    // which grant pulse fired in each instance. Returns just after the edge that
    // moved the FSM into R_RESP.
    task automatic grant_next(output bit ok, output int waited,
                              output logic [1:0] who, output logic [1:0] fp_who);
        ok     = 1'b0;
        waited = 0;
        who    = 2'b00;
        fp_who = 2'b00;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
            step();
        end
        if (ok) begin
            step();
            rd_rdy = 1'b1;
            @(negedge clk);
            who    = {dc_rd_rdy, ic_rd_rdy};
            fp_who = {fp_dc_rd_rdy, fp_ic_rd_rdy};
            step();
            rd_rdy = 1'b0;
        end
    endtask

    // Drives n back-to-back return beats and counts the steered valids.
    task automatic read_burst(input int n, output int ic_b, output int dc_b);
        ic_b = 0;
        dc_b = 0;
        for (int b = 0; b < n; b++) begin
            ret_valid = 1'b1;
            ret_last  = (b == n - 1);
            @(negedge clk);
            if (ic_ret_valid === 1'b1) ic_b++;
            if (dc_ret_valid === 1'b1) dc_b++;
            step();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
        dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = '0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; wr_rdy = 0; wr_done = 0;
        @(negedge clk);
        checks++;
        if ({rd_req, wr_req, dc_wr_rdy, ic_rd_rdy, dc_rd_rdy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00000",
                     {rd_req, wr_req, dc_wr_rdy, ic_rd_rdy, dc_rd_rdy});
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dc_wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_wr_rdy got %b expected 1", dc_wr_rdy);
        end
    endtask

    task automatic test_ic_line();
        int ic_b;
        int dc_b;
        int pulses;
        step();
        ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0100;
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b0) begin
            errors++;
            $display("FAIL ic_line_idle_rd_req got %b expected 0", rd_req);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rd_req, rd_type, rd_addr} !== {1'b1, 3'b100, 32'h1C00_0100}) begin
            errors++;
            $display("FAIL ic_line_req got %b %b %h expected 1 100 1c000100",
                     rd_req, rd_type, rd_addr);
        end
        pulses = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            if (ic_rd_rdy === 1'b1) pulses++;
        end
        step();
        rd_rdy = 1'b1;
        @(negedge clk);
        if (ic_rd_rdy === 1'b1) pulses++;
        checks++;
        if (ic_rd_rdy !== 1'b1 || dc_rd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ic_line_grant got ic=%b dc=%b expected ic=1 dc=0", ic_rd_rdy, dc_rd_rdy);
        end
        step();
        rd_rdy = 1'b0;
        ic_rd_req = 1'b0;
        @(negedge clk);
        if (ic_rd_rdy === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ic_line_rdy_pulses got %0d expected 1", pulses);
        end
        step();
        read_burst(4, ic_b, dc_b);
        checks++;
        if (ic_b != 4 || dc_b != 0) begin
            errors++;
            $display("FAIL ic_line_beats got ic=%0d dc=%0d expected ic=4 dc=0", ic_b, dc_b);
        end
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b0 || ic_ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL ic_line_back_idle got rd_req=%b ret=%b expected 0 0", rd_req, ic_ret_valid);
        end
    endtask

    task automatic test_dc_word();
        bit ok;
        int waited;
        logic [1:0] who;
        logic [1:0] fp_who;
        int ic_b;
        int dc_b;
        step();
        dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_1004;
        grant_next(ok, waited, who, fp_who);
        dc_rd_req = 1'b0;
        checks++;
        if (!ok || who !== 2'b10 || rd_type !== 3'b010 || rd_addr !== 32'h0000_1004) begin
            errors++;
            $display("FAIL dc_word_grant got ok=%0d who=%b type=%b addr=%h expected 1 10 010 00001004",
                     ok, who, rd_type, rd_addr);
        end
        read_burst(1, ic_b, dc_b);
        checks++;
        if (ic_b != 0 || dc_b != 1) begin
            errors++;
            $display("FAIL dc_word_beats got ic=%0d dc=%0d expected ic=0 dc=1", ic_b, dc_b);
        end
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b0 || dc_ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL dc_word_idle got rd_req=%b ret=%b expected 0 0", rd_req, dc_ret_valid);
        end
    endtask

    // Round-robin enters with dcache as last winner, so it goes IC, DC, IC.
    task automatic test_back_to_back();
        bit ok;
        int waited;
        logic [1:0] who;
        logic [1:0] fp_who;
        logic [1:0] exp_rr [3];
        logic [31:0] exp_addr [3];
        int ic_b;
        int dc_b;
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
        exp_addr[0] = 32'h1C00_0200; exp_addr[1] = 32'h0000_3000; exp_addr[2] = 32'h1C00_0200;
        step();
        ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h1C00_0200;
        dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_3000;
        for (int r = 0; r < 3; r++) begin
            grant_next(ok, waited, who, fp_who);
            checks++;
            if (!ok || who !== exp_rr[r] || rd_addr !== exp_addr[r]) begin
                errors++;
                $display("FAIL rr_round%0d got ok=%0d who=%b addr=%h expected 1 %b %h",
                         r, ok, who, rd_addr, exp_rr[r], exp_addr[r]);
            end
            checks++;
            if (fp_who !== 2'b10) begin
                errors++;
                $display("FAIL prio_round%0d got who=%b expected 10", r, fp_who);
            end
            if (r > 0) begin
                checks++;
                if (waited != 1) begin
                    errors++;
                    $display("FAIL rr_regrant_gap%0d got %0d expected 1", r, waited);
                end
            end
            read_burst(1, ic_b, dc_b);
        end
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_stall();
        int bad;
        step();
        dc_wr_req = 1'b1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_4000;
        dc_wr_wstrb = 4'hF; dc_wr_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        step();
        dc_wr_req = 1'b0; dc_wr_data = '0; dc_wr_addr = 32'h0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wr_req !== 1'b1 || dc_wr_rdy !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wr_stall_hold got %0d bad cycles expected 0", bad);
        end
        checks++;
        if ({wr_type, wr_addr, wr_wstrb} !== {3'b100, 32'h0000_4000, 4'hF} ||
            wr_data !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA) begin
            errors++;
            $display("FAIL wr_buffer got %b %h %h %h expected 100 00004000 f deadbeef0123456789abcdef5555aaaa",
                     wr_type, wr_addr, wr_wstrb, wr_data);
        end
        wr_rdy = 1'b1;
        step();
        wr_rdy = 1'b0;
        dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_9990;
        @(negedge clk);
        checks++;
        if (wr_req !== 1'b0 || dc_wr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait_state got req=%b rdy=%b expected 0 0", wr_req, dc_wr_rdy);
        end
        step();
        dc_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_addr !== 32'h0000_4000 || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_protocol_err got addr=%h req=%b expected 00004000 0", wr_addr, wr_req);
        end
        step();
        wr_done = 1'b1;
        @(negedge clk);
        checks++;
        if (dc_wr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL wr_done_cycle got %b expected 0", dc_wr_rdy);
        end
        step();
        wr_done = 1'b0;
        @(negedge clk);
        checks++;
        if (dc_wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL wr_after_done got %b expected 1", dc_wr_rdy);
        end
    endtask

    // Reads raised in the same cycle as the write pulse; the dcache read hits the line.
    task automatic test_hazard();
        bit ok;
        int waited;
        logic [1:0] who;
        logic [1:0] fp_who;
        int ic_b;
        int dc_b;
        int bad;
        step();
        dc_wr_req = 1'b1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_2340;
        dc_wr_wstrb = 4'h0; dc_wr_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_2348;
        ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0000;
        step();
        dc_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h0000_2340) begin
            errors++;
            $display("FAIL hz_write_latched got req=%b addr=%h expected 1 00002340", wr_req, wr_addr);
        end
        grant_next(ok, waited, who, fp_who);
        ic_rd_req = 1'b0;
        checks++;
        if (!ok || who !== 2'b01 || fp_who !== 2'b01 || rd_addr !== 32'h1C00_0000) begin
            errors++;
            $display("FAIL hz_ic_first got ok=%0d rr=%b fp=%b addr=%h expected 1 01 01 1c000000",
                     ok, who, fp_who, rd_addr);
        end
        read_burst(4, ic_b, dc_b);
        checks++;
        if (ic_b != 4 || dc_b != 0) begin
            errors++;
            $display("FAIL hz_ic_beats got ic=%0d dc=%0d expected 4 0", ic_b, dc_b);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rd_req !== 1'b0) bad++;
            step();
        end
        wr_rdy = 1'b1;
        step();
        wr_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rd_req !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hz_dc_blocked got %0d cycles with rd_req expected 0", bad);
        end
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        grant_next(ok, waited, who, fp_who);
        dc_rd_req = 1'b0;
        checks++;
        if (!ok || who !== 2'b10 || rd_addr !== 32'h0000_2348 || waited != 1) begin
            errors++;
            $display("FAIL hz_dc_after_done got ok=%0d who=%b addr=%h wait=%0d expected 1 10 00002348 1",
                     ok, who, rd_addr, waited);
        end
        read_burst(1, ic_b, dc_b);
        checks++;
        if (dc_b != 1 || ic_b != 0) begin
            errors++;
            $display("FAIL hz_dc_beats got ic=%0d dc=%0d expected 0 1", ic_b, dc_b);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int waited;
        logic [1:0] who;
        logic [1:0] fp_who;
        int ic_b;
        int dc_b;
        step();
        dc_wr_req = 1'b1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_5000;
        step();
        dc_wr_req = 1'b0;
        wr_rdy = 1'b1;
        step();
        wr_rdy = 1'b0;
        ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0300;
        grant_next(ok, waited, who, fp_who);
        ic_rd_req = 1'b0;
        checks++;
        if (!ok || who !== 2'b01) begin
            errors++;
            $display("FAIL rst_pre_grant got ok=%0d who=%b expected 1 01", ok, who);
        end
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ic_ret_valid !== 1'b1 || dc_wr_rdy !== 1'b0 || rd_addr !== 32'h1C00_0300) begin
            errors++;
            $display("FAIL rst_pre_state got ret=%b wr_rdy=%b addr=%h expected 1 0 1c000300",
                     ic_ret_valid, dc_wr_rdy, rd_addr);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ic_ret_valid, dc_ret_valid, ic_rd_rdy, dc_rd_rdy, rd_req, wr_req, dc_wr_rdy} !== 7'b0 ||
            rd_addr !== 32'h0 || wr_addr !== 32'h0 || rd_type !== 3'b0 || wr_type !== 3'b0) begin
            errors++;
            $display("FAIL rst_async got flags=%b rd_addr=%h wr_addr=%h expected 0000000 0 0",
                     {ic_ret_valid, dc_ret_valid, ic_rd_rdy, dc_rd_rdy, rd_req, wr_req, dc_wr_rdy},
                     rd_addr, wr_addr);
        end
        step();
        ret_valid = 1'b0;
        ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h1C00_0400;
        dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_6000;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dc_wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_wr_rdy got %b expected 1", dc_wr_rdy);
        end
        step();
        grant_next(ok, waited, who, fp_who);
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
        checks++;
        if (!ok || who !== 2'b10 || fp_who !== 2'b10) begin
            errors++;
            $display("FAIL rst_first_grant got ok=%0d rr=%b fp=%b expected 1 10 10", ok, who, fp_who);
        end
        read_burst(1, ic_b, dc_b);
    endtask

    initial begin
        test_reset();
        test_ic_line();
        test_dc_word();
        test_back_to_back();
        test_write_stall();
        test_hazard();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
